// File: rtl/rdc_fault_monitor_if.sv
// ADC sample stream into the RDC fault monitor.
// The master drives packed channel samples plus a per-cycle valid strobe.
interface rdc_fault_monitor_if #(
    parameter int N_CH = 2,
    parameter int W    = 14
);
    logic [N_CH*W-1:0] samples_i;
    logic              sample_valid_i;

    modport master (output samples_i, output sample_valid_i);
    modport slave  (input  samples_i, input  sample_valid_i);
endinterface

// File: rtl/rdc_fault_monitor.sv
// Multi-channel ADC fault monitor: clipping, LOS, overrange, mismatch, timeout.
// Define RDC_FAULT_MON_PEAK_OUT_EN to hold each window's peaks on peak_abs_o.
module rdc_fault_monitor #(
    parameter int N_CH           = 2,
    parameter int ADC_RESOLUTION = 14,
    parameter int WINDOW_LEN     = 1024,
    parameter int DEBOUNCE       = 2,
    parameter int TIMEOUT        = 4096
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    rdc_fault_monitor_if.slave                  adc,
    input  logic [ADC_RESOLUTION-2:0]           los_thresh_i,
    input  logic [ADC_RESOLUTION-2:0]           overrange_thresh_i,
    input  logic [ADC_RESOLUTION-2:0]           mismatch_thresh_i,
    input  logic [7:0]                          error_mask_i,
    input  logic [7:0]                          error_clear_i,
    output logic [7:0]                          error_o,
    output logic                                window_done_o,
    output logic [N_CH*(ADC_RESOLUTION-1)-1:0]  peak_abs_o
);
    localparam int W  = ADC_RESOLUTION;
    localparam int M  = W - 1;
    localparam int CW = $clog2(WINDOW_LEN);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [M-1:0]  MAG_MAX  = {M{1'b1}};
    localparam logic [W-1:0]  POS_FS   = {1'b0, {M{1'b1}}};
    localparam logic [W-1:0]  NEG_FS   = {1'b1, {M{1'b0}}};
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(WINDOW_LEN - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, EVAL} state_e;

    state_e                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [N_CH-1:0][M-1:0] peak_q;
    logic [DW-1:0]          los_cnt_q, ovr_cnt_q, mis_cnt_q;
    logic [DW-1:0]          los_cnt_d, ovr_cnt_d, mis_cnt_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [7:0]             sticky_q, sticky_d, set_ev;
    logic                   window_done_q;

    logic [N_CH-1:0][W-1:0] smp, neg;
    logic [N_CH-1:0][M-1:0] mag, peak_acc;
    logic [M-1:0]           pk_max, pk_min;
    logic                   clip, los_f, ovr_f, mis_f, eval, valid;

    assign smp   = adc.samples_i;
    assign valid = adc.sample_valid_i;

    always_comb begin
        clip     = 1'b0;
        los_f    = 1'b0;
        ovr_f    = 1'b0;
        pk_max   = '0;
        pk_min   = MAG_MAX;
        neg      = '0;
        mag      = '0;
        peak_acc = '0;
        for (int c = 0; c < N_CH; c++) begin
            neg[c] = ~smp[c] + 1'b1;
            // most-negative code has no positive twin, so saturate it
            if (!smp[c][W-1])           mag[c] = smp[c][M-1:0];
            else if (smp[c] == NEG_FS)  mag[c] = MAG_MAX;
            else                        mag[c] = neg[c][M-1:0];
            peak_acc[c] = (mag[c] > peak_q[c]) ? mag[c] : peak_q[c];
            clip  = clip | (smp[c] == POS_FS) | (smp[c] == NEG_FS);
            los_f = los_f | (peak_q[c] < los_thresh_i);
            ovr_f = ovr_f | (peak_q[c] > overrange_thresh_i);
            if (peak_q[c] > pk_max) pk_max = peak_q[c];
            if (peak_q[c] < pk_min) pk_min = peak_q[c];
        end
        mis_f = (pk_max - pk_min) > mismatch_thresh_i;
    end

    function automatic logic [DW-1:0] deb_next(input logic f,
                                               input logic [DW-1:0] c);
        if (!f) return '0;
        return (c == DEB_MAX) ? c : c + 1'b1;
    endfunction

    always_comb begin
        eval      = (state_q == EVAL);
        los_cnt_d = deb_next(los_f, los_cnt_q);
        ovr_cnt_d = deb_next(ovr_f, ovr_cnt_q);
        mis_cnt_d = deb_next(mis_f, mis_cnt_q);
        if (valid)                tmo_d = '0;
        else if (tmo_q == TMO_MAX) tmo_d = tmo_q;
        else                      tmo_d = tmo_q + 1'b1;
        set_ev    = '0;
        set_ev[0] = valid & clip;
        set_ev[1] = eval & los_f & (los_cnt_d == DEB_MAX);
        set_ev[2] = eval & ovr_f & (ovr_cnt_d == DEB_MAX);
        set_ev[3] = eval & mis_f & (mis_cnt_d == DEB_MAX);
        set_ev[4] = (tmo_d == TMO_MAX);
        sticky_d  = (sticky_q & ~error_clear_i) | set_ev;
    end

`ifdef RDC_FAULT_MON_PEAK_OUT_EN
    logic [N_CH-1:0][M-1:0] peak_out_q;
    assign peak_abs_o = peak_out_q;
`else
    assign peak_abs_o = '0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            peak_q        <= '0;
            los_cnt_q     <= '0;
            ovr_cnt_q     <= '0;
            mis_cnt_q     <= '0;
            tmo_q         <= '0;
            sticky_q      <= '0;
            window_done_q <= 1'b0;
`ifdef RDC_FAULT_MON_PEAK_OUT_EN
            peak_out_q    <= '0;
`endif
        end else begin
            tmo_q         <= tmo_d;
            sticky_q      <= sticky_d;
            window_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (valid) begin
                        peak_q  <= mag;
                        cnt_q   <= CW'(1);
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (valid) begin
                        peak_q <= peak_acc;
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            state_q       <= EVAL;
                            window_done_q <= 1'b1;
                        end
                    end
                end
                EVAL: begin
                    los_cnt_q <= los_cnt_d;
                    ovr_cnt_q <= ovr_cnt_d;
                    mis_cnt_q <= mis_cnt_d;
`ifdef RDC_FAULT_MON_PEAK_OUT_EN
                    peak_out_q <= peak_q;
`endif
                    // a sample arriving now opens the next window
                    peak_q  <= valid ? mag : '0;
                    cnt_q   <= valid ? CW'(1) : '0;
                    state_q <= ACCUM;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign error_o       = sticky_q & error_mask_i;
    assign window_done_o = window_done_q;
endmodule

// File: tb/tb_rdc_fault_monitor.sv
// Randomized bench for rdc_fault_monitor against a window-queue model.
// Directed phases pin the model with literal expectations.
module tb_rdc_fault_monitor;
    localparam int N_CH = 2;
    localparam int W    = 14;
    localparam int M    = 13;
    localparam int WL   = 16;
    localparam int DEB  = 2;
    localparam int TMO  = 64;

    typedef logic [N_CH-1:0][M-1:0] ent_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [M-1:0]      los_th, ovr_th, mis_th;
    logic [7:0]        mask, clr, err;
    logic              done;
    logic [N_CH*M-1:0] peak;

    rdc_fault_monitor_if #(.N_CH(N_CH), .W(W)) bus ();

    rdc_fault_monitor #(
        .N_CH(N_CH), .ADC_RESOLUTION(W), .WINDOW_LEN(WL),
        .DEBOUNCE(DEB), .TIMEOUT(TMO)
    ) dut (
        .clk_i(clk), .reset_i(rst), .adc(bus),
        .los_thresh_i(los_th), .overrange_thresh_i(ovr_th),
        .mismatch_thresh_i(mis_th), .error_mask_i(mask),
        .error_clear_i(clr), .error_o(err),
        .window_done_o(done), .peak_abs_o(peak)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int amp[N_CH];
    int cur_s[N_CH];
    bit cur_v;
    int vprob, clip_pct, ph;
    bit rnd_en, started;

    ent_t win[$], full[$];
    int   m_idle, m_evals, st_los, st_ovr, st_mis;
    int   m_pk[N_CH];
    bit   m_done;
    logic [7:0] m_sticky;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic int magof(int s);
        if (s == -8192) return 8191;
        return (s < 0) ? -s : s;
    endfunction

    function automatic logic [31:0] exp_peak();
        logic [31:0] r = '0;
`ifdef RDC_FAULT_MON_PEAK_OUT_EN
        for (int c = 0; c < N_CH; c++) r[c*M +: M] = M'(m_pk[c]);
`endif
        return r;
    endfunction

    function automatic int gen(int c);
        int a, m, r;
        a = amp[c];
        if (!rnd_en) return a;
        m = (ph % 4 == 0) ? a : int'($urandom_range(a, 0));
        r = ($urandom_range(1, 0) == 1) ? m : -m;
        if (clip_pct > 0 && int'($urandom_range(99, 0)) < clip_pct)
            r = ($urandom_range(1, 0) == 1) ? 8191 : -8192;
        return r;
    endfunction

    task automatic model_step();
        logic [7:0] se = '0;
        ent_t e;
        int pk[N_CH];
        int mx, mn;
        bit lf, of;
        if (rst) begin
            m_sticky = '0; m_done = 0; m_idle = 0;
            st_los = 0; st_ovr = 0; st_mis = 0;
            win.delete(); full.delete();
            m_pk = '{default: 0};
            return;
        end
        if (cur_v)
            for (int c = 0; c < N_CH; c++)
                if (cur_s[c] == 8191 || cur_s[c] == -8192) se[0] = 1'b1;
        m_idle = cur_v ? 0 : (m_idle < TMO ? m_idle + 1 : TMO);
        if (m_idle == TMO) se[4] = 1'b1;
        if (m_done) begin
            for (int c = 0; c < N_CH; c++) pk[c] = 0;
            foreach (full[i])
                for (int c = 0; c < N_CH; c++)
                    if (int'(full[i][c]) > pk[c]) pk[c] = int'(full[i][c]);
            lf = 0; of = 0; mx = 0; mn = 8191;
            for (int c = 0; c < N_CH; c++) begin
                if (pk[c] < int'(los_th)) lf = 1;
                if (pk[c] > int'(ovr_th)) of = 1;
                if (pk[c] > mx) mx = pk[c];
                if (pk[c] < mn) mn = pk[c];
            end
            st_los = lf ? (st_los < DEB ? st_los + 1 : DEB) : 0;
            st_ovr = of ? (st_ovr < DEB ? st_ovr + 1 : DEB) : 0;
            st_mis = (mx - mn > int'(mis_th)) ? (st_mis < DEB ? st_mis + 1 : DEB) : 0;
            if (st_los == DEB) se[1] = 1'b1;
            if (st_ovr == DEB) se[2] = 1'b1;
            if (st_mis == DEB) se[3] = 1'b1;
            m_pk = pk;
            m_evals++;
        end
        m_done = 0;
        if (cur_v) begin
            for (int c = 0; c < N_CH; c++) e[c] = M'(magof(cur_s[c]));
            win.push_back(e);
            if (win.size() == WL) begin
                full = win;
                win.delete();
                m_done = 1;
            end
        end
        m_sticky = (m_sticky & ~clr) | se;
    endtask

    task automatic tick();
        logic [N_CH*W-1:0] sv;
        cur_v = int'($urandom_range(99, 0)) < vprob;
        for (int c = 0; c < N_CH; c++) begin
            cur_s[c] = gen(c);
            sv[c*W +: W] = W'(cur_s[c]);
        end
        bus.samples_i      = sv;
        bus.sample_valid_i = cur_v;
        ph++;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic run_evals(int k);
        int tgt = m_evals + k;
        int b = 0;
        while (m_evals < tgt && b < 200) begin tick(); b++; end
        if (m_evals < tgt) begin
            n_chk++;
            $display("FAIL run_evals: reached %0d evals, required %0d", m_evals, tgt);
        end
    endtask

    task automatic wait_eval_cycle();
        int b = 0;
        while (!m_done && b < 200) begin tick(); b++; end
        if (!m_done) begin
            n_chk++;
            $display("FAIL wait_eval: no EVAL cycle within budget");
        end
    endtask

    always @(negedge clk) if (started) begin
        chk("error_o", {24'd0, err}, {24'd0, m_sticky & mask});
        chk("window_done_o", {31'd0, done}, {31'd0, m_done});
        chk("peak_abs_o", {6'd0, peak}, exp_peak());
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; clr = '0; mask = 8'hFF;
        los_th = '0; ovr_th = 13'd8191; mis_th = 13'd8191;
        amp = '{4096, 4096}; vprob = 100; clip_pct = 0; ph = 0;
        rnd_en = 0; m_evals = 0;
        bus.samples_i = '0; bus.sample_valid_i = 1'b0;
        do_reset(); do_reset();
        started = 1;

        // clipping
        repeat (3) tick();
        amp[0] = 8191; tick(); amp[0] = 4096;
        chk("clip_set", {31'd0, err[0]}, 32'd1);
        clr = 8'h01; tick(); clr = '0;
        chk("clip_clear", {31'd0, err[0]}, 32'd0);
        repeat (5) tick();
        chk("clip_stays_clear", {31'd0, err[0]}, 32'd0);

        // LOS
        do_reset(); rnd_en = 1; los_th = 13'd256;
        run_evals(4);
        chk("los_clean", {31'd0, err[1]}, 32'd0);
        los_th = 13'd8191;
        run_evals(1);
        chk("los_first_eval", {31'd0, err[1]}, 32'd0);
        run_evals(1);
        chk("los_second_eval", {31'd0, err[1]}, 32'd1);

        // overrange
        do_reset(); los_th = '0; ovr_th = 13'd8191;
        run_evals(2);
        chk("ovr_clean", {31'd0, err[2]}, 32'd0);
        ovr_th = 13'd256;
        run_evals(2);
        chk("ovr_latched", {31'd0, err[2]}, 32'd1);
        wait_eval_cycle();
        clr = 8'h04; tick(); clr = '0;
        chk("ovr_set_wins", {31'd0, err[2]}, 32'd1);
        clr = 8'h04; tick(); clr = '0;
        chk("ovr_cleared", {31'd0, err[2]}, 32'd0);
        run_evals(1);
        chk("ovr_relatch", {31'd0, err[2]}, 32'd1);

        // mismatch
        do_reset(); ovr_th = 13'd8191; amp = '{4100, 4076}; mis_th = 13'd4096;
        run_evals(2);
        chk("mis_clean", {31'd0, err[3]}, 32'd0);
        mis_th = '0;
        run_evals(2);
        chk("mis_latched", {31'd0, err[3]}, 32'd1);
        do_reset(); mis_th = '0;
        run_evals(1);
        mis_th = 13'd4096; run_evals(1);
        mis_th = '0; run_evals(1);
        chk("mis_broken_streak", {31'd0, err[3]}, 32'd0);
        run_evals(1);
        chk("mis_after_streak", {31'd0, err[3]}, 32'd1);

        // timeout and mask
        do_reset(); mis_th = 13'd8191; amp = '{4096, 4096};
        repeat (5) tick();
        mask = 8'hEF; vprob = 0;
        repeat (64) tick();
        chk("tmo_masked", {24'd0, err}, 32'd0);
        mask = 8'hFF; #1;
        chk("tmo_unmasked", {31'd0, err[4]}, 32'd1);
        vprob = 100;
        repeat (10) tick();
        chk("tmo_partial_15", {31'd0, done}, 32'd0);
        tick();
        chk("tmo_partial_16", {31'd0, done}, 32'd1);

        // reset mid-window
        do_reset();
        rnd_en = 0; amp[0] = 8191; tick(); amp[0] = 4096; rnd_en = 1;
        repeat (9) tick();
        chk("pre_reset_clip", {31'd0, err[0]}, 32'd1);
        do_reset();
        chk("rst_error", {24'd0, err}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_peak", {6'd0, peak}, 32'd0);
        vprob = 0; repeat (3) tick();
        vprob = 100; repeat (15) tick();
        chk("rst_win_15", {31'd0, done}, 32'd0);
        tick();
        chk("rst_win_16", {31'd0, done}, 32'd1);

        // randomized traffic
        for (int blk = 0; blk < 15; blk++) begin
            los_th   = M'($urandom_range(6000, 0));
            ovr_th   = M'($urandom_range(8191, 2000));
            mis_th   = M'($urandom_range(3000, 0));
            amp[0]   = $urandom_range(8191, 0);
            amp[1]   = $urandom_range(8191, 0);
            vprob    = ($urandom_range(3, 0) == 0) ? $urandom_range(30, 0)
                                                   : $urandom_range(100, 60);
            mask     = 8'($urandom);
            clip_pct = $urandom_range(3, 0);
            for (int i = 0; i < 200; i++) begin
                clr = ($urandom_range(19, 0) == 0) ? 8'($urandom) : 8'h00;
                if ($urandom_range(499, 0) == 0) rst = 1'b1;
                tick();
                rst = 1'b0;
            end
        end
        clr = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rdc_fault_monitor.md
Name: rdc_fault_monitor

Overview:
- Parametrised multi-channel successor of the two-channel RDC error detector. Monitors N_CH resolver/RVDT ADC channels for clipping, loss of signal (LOS), overrange, inter-channel amplitude mismatch and sample-stream timeout.
- Sits between the ADC sample inputs and the rdc_top register block.
- Detections are debounced and held in a sticky error register with per-bit enable mask and per-bit clear.

Parameters:
N_CH, 2, number of monitored channels (2..8)
ADC_RESOLUTION, 14, sample width W, signed two's complement
WINDOW_LEN, 1024, valid samples per peak-evaluation window (power of 2, >=4)
DEBOUNCE, 2, consecutive faulty windows required to latch LOS/overrange/mismatch (1..15)
TIMEOUT, 4096, clock cycles without sample_valid_i before timeout fault

Ports:
clk_i  in  1  system clock
reset_i  in  1  synchronous, active-high reset
samples_i  in  N_CH*W  packed channel samples, channel 0 in LSBs
sample_valid_i  in  1  samples_i valid this cycle
los_thresh_i  in  W-1  minimum allowed peak magnitude
overrange_thresh_i  in  W-1  maximum allowed peak magnitude
mismatch_thresh_i  in  W-1  maximum allowed (max peak - min peak)
error_mask_i  in  8  per-bit enable for error_o
error_clear_i  in  8  per-bit single-cycle clear of sticky bits
error_o  out  8  masked sticky errors
window_done_o  out  1  one-cycle pulse when a window is evaluated
peak_abs_o  out  N_CH*(W-1)  last-window peak magnitude per channel (see optional feature)

Behaviour:
- Reset: all outputs, peak accumulators, window counter, debounce counters, timeout counter and sticky bits go to 0. The FSM enters IDLE.
- Magnitude: |x| saturates to 2^(W-1)-1. For -2^(W-1), |x| = 2^(W-1)-1. Comparisons are unsigned on W-1 bits.
- Error bit map:
  - [0] clipping: any sample equals 2^(W-1)-1 or -2^(W-1).
  - [1] LOS: any channel peak < los_thresh.
  - [2] overrange: any channel peak > overrange_thresh.
  - [3] mismatch: max peak - min peak > mismatch_thresh.
  - [4] timeout.
  - [7:5] reserved, always 0.
- FSM:
  - IDLE -> ACCUM on first sample_valid_i. That sample is accumulated.
  - ACCUM: on each valid sample, peak[c] <= max(peak[c], |x_c|) and the window counter increments. When the counter reaches WINDOW_LEN, go to EVAL.
  - EVAL (exactly one cycle): compare the peaks, update the debounce counters, copy peaks to peak_abs_o, pulse window_done_o, clear the accumulators and counter, return to ACCUM.
  - A sample_valid_i during EVAL is accumulated into the new window. It is never dropped.
- Clipping is evaluated per valid sample. The sticky bit sets 1 cycle after the sample (registered), with no debounce.
- Debounce counters, one each for LOS, overrange and mismatch:
  - A faulty window increments the counter, saturating at DEBOUNCE.
  - A clean window resets it to 0.
  - The sticky bit sets in the EVAL cycle where the counter reaches DEBOUNCE, visible on error_o the next cycle.
- Timeout:
  - Counter increments each cycle without sample_valid_i and resets on valid.
  - Reaching TIMEOUT sets bit 4. The counter saturates.
  - Timeout does not alter FSM state or the partial window.
- Sticky register: sticky <= (sticky & ~error_clear_i) | set_events. A set and a clear on the same bit in the same cycle leaves the bit set (set wins).
- error_o = sticky & error_mask_i, combinational from the register. Masked bits still latch internally and appear as soon as they are unmasked.
- Clear does not reset the debounce counters. A persistent fault therefore re-latches at the next EVAL.
- Threshold changes take effect at the next EVAL. There is no mid-window restart.
- Reset asserted mid-window discards the partial window and returns the FSM to IDLE.
- N_CH=1: mismatch is never flagged (max=min).

Optional Feature:
Macro RDC_FAULT_MON_PEAK_OUT_EN.
- Defined: peak_abs_o carries registered per-channel peaks, updated in EVAL and held until the next EVAL.
- Undefined: peak_abs_o is tied to 0 and no holding registers are synthesised. All error behaviour is identical.

Test Plan:
Common setup: N_CH=2, W=14, WINDOW_LEN=16, DEBOUNCE=2, TIMEOUT=64, mask=8'hFF, valid every cycle unless stated.
1. Clipping: ch0 sample 14'h1FFF once, rest 14'h1000 -> error_o[0]=1 one cycle later. Clear 8'h01 with signal back to 14'h1000 -> bit 0 = 0 and stays 0.
2. LOS: constant amplitude 4096, los_thresh 256 -> error_o[1]=0 after 4 windows. los_thresh 8191 -> bit 1 still 0 after the first EVAL, 1 after the second EVAL.
3. Overrange: overrange_thresh 8191 -> bit 2=0. Set to 256 -> bit 2=1 after 2 windows. Same-cycle clear and set -> bit 2 remains 1.
4. Mismatch: ch0 peak 4100, ch1 peak 4076 (delta 24), thresh 4096 -> bit 3=0. Thresh 0 -> bit 3=1 after 2 windows. A clean window between two faulty windows prevents latching.
5. Timeout and mask: deassert valid for 64 cycles with mask 8'hEF -> error_o[4]=0. Mask 8'hFF -> error_o[4]=1 immediately. Valid resumes -> window count continues from the partial value.
6. Reset mid-window after 10 samples -> all outputs 0. The next window_done_o comes 16 valid samples after the first valid sample post-reset.
